// File: rtl/stream_arb_2x1_if.sv
// Handshake bundle for the 2:1 packet-aware stream arbiter: two source channels
// (A, B) and one registered output channel (F) with its source select.
interface stream_arb_2x1_if #(
    parameter int WIDTH = 8
);
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_last;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_last;

    logic             f_valid;
    logic             f_ready;
    logic [WIDTH-1:0] f_data;
    logic             f_last;
    logic             f_sel;

    // Arbiter side of the bundle.
    modport slave (
        input  a_valid, a_data, a_last,
        input  b_valid, b_data, b_last,
        input  f_ready,
        output a_ready, b_ready,
        output f_valid, f_data, f_last, f_sel
    );

    // Environment side: drives both sources and sinks the output.
    modport master (
        output a_valid, a_data, a_last,
        output b_valid, b_data, b_last,
        output f_ready,
        input  a_ready, b_ready,
        input  f_valid, f_data, f_last, f_sel
    );
endinterface

// File: rtl/stream_arb_2x1.sv
// 2:1 round-robin stream arbiter that keeps packets whole and registers its output.
// Define STREAM_ARB_CNT_EN to build the per-source completed-packet counters.
module stream_arb_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_arb_2x1_if.slave     s,
    output logic [15:0]         cnt_a,
    output logic [15:0]         cnt_b
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic             grant_a, grant_b;
    logic             free;

    logic             f_valid_q;
    logic [WIDTH-1:0] f_data_q;
    logic             f_last_q;
    logic             f_sel_q;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign free = !f_valid_q || s.f_ready;

    // NOTE: every variable written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;

        unique case (state_q)
            IDLE: begin
                if (free) begin
                    if (s.a_valid && s.b_valid) begin
                        grant_a = last_grant_q;
                        grant_b = !last_grant_q;
                    end else begin
                        grant_a = s.a_valid;
                        grant_b = s.b_valid;
                    end
                end
            end
            LOCK_A:  grant_a = free && s.a_valid;
            LOCK_B:  grant_b = free && s.b_valid;
            default: ;
        endcase

        // A grant is always an accepted beat, since grants already require valid.
        if (grant_a) begin
            if (s.a_last) begin
                state_d      = IDLE;
                last_grant_d = 1'b0;
            end else begin
                state_d      = LOCK_A;
            end
        end else if (grant_b) begin
            if (s.b_last) begin
                state_d      = IDLE;
                last_grant_d = 1'b1;
            end else begin
                state_d      = LOCK_B;
            end
        end
    end

    // Readies are combinational, so they are forced low while reset is held.
    assign s.a_ready = grant_a && rst_n;
    assign s.b_ready = grant_b && rst_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_valid_q <= 1'b0;
            f_data_q  <= '0;
            f_last_q  <= 1'b0;
            f_sel_q   <= 1'b0;
        end else if (grant_a) begin
            f_valid_q <= 1'b1;
            f_data_q  <= s.a_data;
            f_last_q  <= s.a_last;
            f_sel_q   <= 1'b0;
        end else if (grant_b) begin
            f_valid_q <= 1'b1;
            f_data_q  <= s.b_data;
            f_last_q  <= s.b_last;
            f_sel_q   <= 1'b1;
        end else if (s.f_ready) begin
            f_valid_q <= 1'b0;
        end
    end

    assign s.f_valid = f_valid_q;
    assign s.f_data  = f_data_q;
    assign s.f_last  = f_last_q;
    assign s.f_sel   = f_sel_q;

`ifdef STREAM_ARB_CNT_EN
    logic [15:0] cnt_a_q, cnt_b_q;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            if (grant_a && s.a_last) cnt_a_q <= cnt_a_q + 16'd1;
            if (grant_b && s.b_last) cnt_b_q <= cnt_b_q + 16'd1;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Self-checking bench for stream_arb_2x1: directed scenarios, then random traffic,
// compared against a packet-level arbitration model. Honours STREAM_ARB_CNT_EN.
module tb_stream_arb_2x1;

    logic        clk;
    logic        rst_n;
    logic [15:0] cnt_a, cnt_b;

    stream_arb_2x1_if #(.WIDTH(8)) bus ();

    stream_arb_2x1 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the output (0 none, 1 A, 2 B), round-robin memory,
    // contents of the output slot and the completed-packet tallies.
    int          m_owner;
    logic        m_b_was_last;
    logic        m_fv;
    logic [7:0]  m_fd;
    logic        m_fl;
    logic        m_fs;
    logic [15:0] m_ca, m_cb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner      = 0;
        m_b_was_last = 1'b1;
        m_fv         = 1'b0;
        m_fd         = 8'h00;
        m_fl         = 1'b0;
        m_fs         = 1'b0;
        m_ca         = 16'd0;
        m_cb         = 16'd0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".f_valid"}, 32'(bus.f_valid), 32'(m_fv));
        if (m_fv) begin
            check({tag, ".f_data"}, 32'(bus.f_data), 32'(m_fd));
            check({tag, ".f_last"}, 32'(bus.f_last), 32'(m_fl));
            check({tag, ".f_sel"},  32'(bus.f_sel),  32'(m_fs));
        end
        check({tag, ".cnt_a"}, 32'(cnt_a), 32'(m_ca));
        check({tag, ".cnt_b"}, 32'(cnt_b), 32'(m_cb));
    endtask

    // One clock cycle: drive inputs, check readies mid-cycle, then check the
    // registered output after the rising edge.
    task automatic step(input logic av, input logic [7:0] ad, input logic al,
                        input logic bv, input logic [7:0] bd, input logic bl,
                        input logic fr, input string tag);
        logic slot_free, ea, eb;
        @(negedge clk);
        bus.a_valid = av; bus.a_data = ad; bus.a_last = al;
        bus.b_valid = bv; bus.b_data = bd; bus.b_last = bl;
        bus.f_ready = fr;
        #1;
        slot_free = !m_fv || fr;
        ea = 1'b0;
        eb = 1'b0;
        if (slot_free) begin
            if (m_owner == 1)        ea = av;
            else if (m_owner == 2)   eb = bv;
            else if (av && bv) begin ea = m_b_was_last; eb = !m_b_was_last; end
            else begin               ea = av; eb = bv; end
        end
        check({tag, ".a_ready"}, 32'(bus.a_ready), 32'(ea));
        check({tag, ".b_ready"}, 32'(bus.b_ready), 32'(eb));
        @(posedge clk);
        if (ea) begin
            m_fv = 1'b1; m_fd = ad; m_fl = al; m_fs = 1'b0;
            if (al) begin
                m_owner = 0; m_b_was_last = 1'b0;
`ifdef STREAM_ARB_CNT_EN
                m_ca = m_ca + 16'd1;
`endif
            end else begin
                m_owner = 1;
            end
        end else if (eb) begin
            m_fv = 1'b1; m_fd = bd; m_fl = bl; m_fs = 1'b1;
            if (bl) begin
                m_owner = 0; m_b_was_last = 1'b1;
`ifdef STREAM_ARB_CNT_EN
                m_cb = m_cb + 16'd1;
`endif
            end else begin
                m_owner = 2;
            end
        end else if (fr) begin
            m_fv = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between clock edges with both sources requesting; all
    // outputs must drop at once without waiting for a clock.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.f_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check({tag, ".f_valid"}, 32'(bus.f_valid), 32'h0);
        check({tag, ".f_data"},  32'(bus.f_data),  32'h0);
        check({tag, ".f_last"},  32'(bus.f_last),  32'h0);
        check({tag, ".f_sel"},   32'(bus.f_sel),   32'h0);
        check({tag, ".a_ready"}, 32'(bus.a_ready), 32'h0);
        check({tag, ".b_ready"}, 32'(bus.b_ready), 32'h0);
        check({tag, ".cnt_a"},   32'(cnt_a),       32'h0);
        check({tag, ".cnt_b"},   32'(cnt_b),       32'h0);
        model_reset();
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.a_valid = 1'b0; bus.a_data = 8'h00; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_last = 1'b0;
        bus.f_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state with both sources requesting during reset.
        pulse_reset("reset");

        // Two-beat A packet, A alone.
        step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "a_pkt0");
        check("a_pkt0.data", 32'(bus.f_data), 32'h11);
        step(1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "a_pkt1");
        check("a_pkt1.data", 32'(bus.f_data), 32'h22);
        check("a_pkt1.last", 32'(bus.f_last), 32'h1);

        // Contention from reset: single beats alternate starting with A.
        pulse_reset("rst_rr");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hAA, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, "rr");
            check("rr.data", 32'(bus.f_data), (i % 2 == 0) ? 32'hAA : 32'hBB);
        end

        // A three-beat packet holds off B until its last beat.
        step(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, "lock1");
        step(1'b1, 8'hA2, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, "lock2");
        step(1'b1, 8'hA3, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, "lock3");
        check("lock3.data", 32'(bus.f_data), 32'hA3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1, "lock4");
        check("lock4.data", 32'(bus.f_data), 32'hB0);
        check("lock4.sel",  32'(bus.f_sel),  32'h1);

        // Backpressure: beat 5C held for three stalled cycles, then drained once.
        step(1'b1, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "bp0");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h77, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0, "bp_stall");
            check("bp_stall.data", 32'(bus.f_data), 32'h5C);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "bp_drain");
        check("bp_drain.valid", 32'(bus.f_valid), 32'h0);

        // Reset in the middle of a B packet, then A must win the next contention.
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, "midrst0");
        pulse_reset("midrst");
        step(1'b1, 8'hC1, 1'b1, 1'b1, 8'hD1, 1'b1, 1'b1, "midrst1");
        check("midrst1.sel", 32'(bus.f_sel), 32'h0);

        // Random traffic, including idle sources mid-packet and backpressure.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0,
                 ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0,
                 ($urandom % 4) != 0, "rand");
        end

        // Counter wrap: 65537 single-beat A packets.
        pulse_reset("rst_wrap");
        for (int i = 0; i < 65537; i++) begin
            step(1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "wrap");
        end
`ifdef STREAM_ARB_CNT_EN
        check("wrap.cnt_a", 32'(cnt_a), 32'h1);
`else
        check("wrap.cnt_a", 32'(cnt_a), 32'h0);
`endif
        check("wrap.cnt_b", 32'(cnt_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
